instruction_encoder: RTL and testbench

Encodes symbolic instruction requests into 32-bit instruction words and writes them sequentially into the 32-entry instruction memory. It is the producer side of the fetch/decode path: every word it emits follows the same field layout the decode stage parses. It serves as the loader path in place of file preloading. It accepts one request per cycle on a valid/ready handshake and tracks the fill level.

---
 rtl/isa_pkg.sv | 49 ++++
 rtl/instr_field_packer.sv | 56 +++++
 rtl/instruction_encoder.sv | 113 +++++++++++
 tb/tb_instruction_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isa_pkg
//  Description : Shared instruction-set definitions: op enum, 17-bit opcode
//                patterns and instruction-word field positions. Imported by
//                both the encoder (producer) and the decode stage (consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    // Symbolic operations as presented on the request interface
    typedef enum logic [2:0] {
        OP_LDI = 3'd0,
        OP_MOV = 3'd1,
        OP_CLR = 3'd2,
        OP_SET = 3'd3,
        OP_CPY = 3'd4,
        OP_ADD = 3'd5,
        OP_IDX = 3'd6,
        OP_ILL = 3'd7
    } op_e;

    // Fill-level state of the instruction memory loader
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } fill_state_e;

    // Field bit positions within the 32-bit instruction word
    localparam int TARGET_MSB = 31;
    localparam int TARGET_LSB = 27;
    localparam int SRC_A_MSB  = 26;
    localparam int SRC_A_LSB  = 22;
    localparam int SRC_B_MSB  = 21;
    localparam int SRC_B_LSB  = 17;
    localparam int OPC_W      = 17;

    // Opcode patterns occupying bits [16:0]
    localparam logic [OPC_W-1:0] OPC_LDI = 17'b10000000010101010;
    localparam logic [OPC_W-1:0] OPC_MOV = 17'b10000001101010101;
    localparam logic [OPC_W-1:0] OPC_CLR = 17'b10000010011011011;
    localparam logic [OPC_W-1:0] OPC_SET = 17'b10000011111111111;
    localparam logic [OPC_W-1:0] OPC_CPY = 17'b10000100101101101;
    localparam logic [OPC_W-1:0] OPC_ADD = 17'b10000101101111100;
    localparam logic [OPC_W-1:0] OPC_IDX = 17'b10001011010101010;

endpackage : isa_pkg
`default_nettype wire

// File: rtl/instr_field_packer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_field_packer
//  Description : Combinational packer mapping an op and its operand fields
//                to the masked 32-bit instruction word, plus a legal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_field_packer
    import isa_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  target,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    output logic [31:0] word,
    output logic        legal
);

    logic [OPC_W-1:0] w_opcode;
    logic [4:0]       w_src_a;
    logic [4:0]       w_src_b;

    // Select opcode pattern and apply per-op operand masking
    always_comb begin
        w_opcode = '0;
        w_src_a  = src_a;
        w_src_b  = 5'd0;          // only ADD carries operand B
        legal    = 1'b1;
        case (op_e'(op))
            OP_LDI: w_opcode = OPC_LDI;
            OP_MOV: w_opcode = OPC_MOV;
            OP_CLR: begin
                w_opcode = OPC_CLR;
                w_src_a  = 5'd0;  // CLR has no operands at all
            end
            OP_SET: w_opcode = OPC_SET;
            OP_CPY: w_opcode = OPC_CPY;
            OP_ADD: begin
                w_opcode = OPC_ADD;
                w_src_b  = src_b;
            end
            OP_IDX: w_opcode = OPC_IDX;
            default: begin
                legal   = 1'b0;
                w_src_a = 5'd0;
            end
        endcase
        word = '0;
        word[TARGET_MSB:TARGET_LSB] = target;
        word[SRC_A_MSB:SRC_A_LSB]   = w_src_a;
        word[SRC_B_MSB:SRC_B_LSB]   = w_src_b;
        word[OPC_W-1:0]             = w_opcode;
    end

endmodule : instr_field_packer
`default_nettype wire

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_encoder
//  Description : Accepts symbolic instruction requests on a valid/ready
//                handshake, encodes them and writes them sequentially into
//                the instruction memory, tracking the fill level.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_encoder
    import isa_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_target,
    input  logic [4:0]  req_src_a,
    input  logic [4:0]  req_src_b,
    input  logic        flush,
    output logic        mem_we,
    output logic [4:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [5:0]  wr_count,
    output logic        full,
    output logic        err_illegal
);

    localparam logic [5:0] C_DEPTH      = 6'(DEPTH);
    localparam logic [5:0] C_DEPTH_LAST = 6'(DEPTH - 1);

    fill_state_e state;
    fill_state_e next_state;
    logic [4:0]  wp;
    logic [31:0] packed_word;
    logic        packed_legal;
    logic        accept;
    logic        write_ok;
    logic        last_slot;

    instr_field_packer u_packer (
        .op     (req_op),
        .target (req_target),
        .src_a  (req_src_a),
        .src_b  (req_src_b),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    // Handshake depends only on state, flush and reset (never on req_valid)
    assign req_ready = (state != ST_FULL) && !flush && reset;
    assign full      = (state == ST_FULL);
    assign accept    = req_valid && req_ready;
    assign write_ok  = accept && packed_legal;
    assign last_slot = (wr_count == C_DEPTH_LAST);

    // Next-state logic for the fill-level FSM
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_EMPTY;
        end else if (write_ok) begin
            next_state = last_slot ? ST_FULL : ST_FILL;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Write pointer, counter and registered memory-write outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp          <= 5'd0;
            wr_count    <= 6'd0;
            mem_we      <= 1'b0;
            mem_addr    <= 5'd0;
            mem_wdata   <= 32'd0;
            err_illegal <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            err_illegal <= 1'b0;
            if (flush) begin
                wp       <= 5'd0;
                wr_count <= 6'd0;
            end else if (write_ok) begin
                mem_we    <= 1'b1;
                mem_addr  <= wp;
                mem_wdata <= packed_word;
                wp        <= last_slot ? 5'd0 : wp + 5'd1;
                wr_count  <= wr_count + 6'd1;
            end else if (accept) begin
                err_illegal <= 1'b1;
            end
        end
    end

    // Fill count can never exceed the memory depth
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (wr_count <= C_DEPTH);
        end
    end

endmodule : instruction_encoder
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_encoder
//  Description : Directed self-checking bench for instruction_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_target;
    logic [4:0]  req_src_a;
    logic [4:0]  req_src_b;
    logic        flush;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [5:0]  wr_count;
    logic        full;
    logic        err_illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [16:0] MOV_PAT = 17'b10000001101010101;

    instruction_encoder #(.DEPTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_target  (req_target),
        .req_src_a   (req_src_a),
        .req_src_b   (req_src_b),
        .flush       (flush),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .wr_count    (wr_count),
        .full        (full),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] t,
                         input logic [4:0] a, input logic [4:0] b);
        req_valid  = v;
        req_op     = op;
        req_target = t;
        req_src_a  = a;
        req_src_b  = b;
    endtask

    initial begin
        logic [31:0] exp_word;
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);

        // Reset held low for two edges
        tick();
        check("ready_in_reset", {31'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_wr_count", {26'd0, wr_count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_err", {31'd0, err_illegal}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        // LDI: src_b masked off
        drive(1'b1, 3'd0, 5'h11, 5'd3, 5'd9);
        tick();
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        check("ldi_we", {31'd0, mem_we}, 32'd1);
        check("ldi_addr", {27'd0, mem_addr}, 32'd0);
        check("ldi_data", mem_wdata, 32'h88C100AA);
        check("ldi_count", {26'd0, wr_count}, 32'd1);
        tick();
        check("ldi_we_drop", {31'd0, mem_we}, 32'd0);

        // Flush back to address 0
        flush = 1'b1;
        #1;
        check("ready_in_flush", {31'd0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush1_count", {26'd0, wr_count}, 32'd0);

        // Back-to-back ADD then CLR
        drive(1'b1, 3'd5, 5'd2, 5'd4, 5'd6);
        tick();
        check("add_addr", {27'd0, mem_addr}, 32'd0);
        check("add_data", mem_wdata, 32'h110D0B7C);
        drive(1'b1, 3'd2, 5'd7, 5'd9, 5'd3);
        tick();
        check("clr_we", {31'd0, mem_we}, 32'd1);
        check("clr_addr", {27'd0, mem_addr}, 32'd1);
        check("clr_data", mem_wdata, 32'h380104DB);
        check("clr_count", {26'd0, wr_count}, 32'd2);

        // Illegal op: handshake completes, nothing written
        drive(1'b1, 3'd7, 5'd1, 5'd1, 5'd1);
        tick();
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        check("ill_err", {31'd0, err_illegal}, 32'd1);
        check("ill_we", {31'd0, mem_we}, 32'd0);
        check("ill_count", {26'd0, wr_count}, 32'd2);
        tick();
        check("ill_err_pulse", {31'd0, err_illegal}, 32'd0);
        drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        check("post_ill_addr", {27'd0, mem_addr}, 32'd2);
        check("post_ill_data", mem_wdata, 32'h000100AA);
        check("post_ill_count", {26'd0, wr_count}, 32'd3);

        // Fill all 32 entries with MOV
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 3'd1, 5'(i), 5'(i), 5'd5);
            tick();
            exp_word = {5'(i), 5'(i), 5'd0, MOV_PAT};
            check("fill_we", {31'd0, mem_we}, 32'd1);
            check("fill_addr", {27'd0, mem_addr}, 32'(i));
            check("fill_data", mem_wdata, exp_word);
            if (i == 30) begin
                check("fill_not_full", {31'd0, full}, 32'd0);
                check("fill_ready", {31'd0, req_ready}, 32'd1);
            end
        end
        check("full_set", {31'd0, full}, 32'd1);
        check("full_ready", {31'd0, req_ready}, 32'd0);
        check("full_count", {26'd0, wr_count}, 32'd32);

        // 33rd request refused
        drive(1'b1, 3'd0, 5'd9, 5'd9, 5'd9);
        tick();
        check("over_we", {31'd0, mem_we}, 32'd0);
        check("over_count", {26'd0, wr_count}, 32'd32);
        check("over_full", {31'd0, full}, 32'd1);

        // Flush with valid still high: no accept during flush
        flush = 1'b1;
        tick();
        check("flush2_we", {31'd0, mem_we}, 32'd0);
        check("flush2_count", {26'd0, wr_count}, 32'd0);
        check("flush2_full", {31'd0, full}, 32'd0);
        flush = 1'b0;
        drive(1'b1, 3'd0, 5'd3, 5'd0, 5'd0);
        tick();
        check("refill_addr", {27'd0, mem_addr}, 32'd0);
        check("refill_data", mem_wdata, 32'h180100AA);
        check("refill_count", {26'd0, wr_count}, 32'd1);

        // Reset in the cycle after an accept discards the write
        drive(1'b1, 3'd3, 5'd1, 5'd2, 5'd3);
        tick();
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
        check("pre_rst_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_count", {26'd0, wr_count}, 32'd0);
        #1;
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_encoder
`default_nettype wire
